// File: rtl/pixel_spi_loader.sv
// rtl/pixel_spi_loader.sv - SPI-slave byte loader feeding the circular pixel buffer
// Deserialises MOSI bytes, strobes each into the buffer and holds off once a full image is stored.
module pixel_spi_loader #(
  parameter int NUM_BYTES  = 72,
  parameter int DATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           sclk,
  input  logic                           ss_n,
  input  logic                           mosi,
  input  logic                           image_ack,
  output logic [DATA_WIDTH-1:0]          spi_in,
  output logic                           write_en,
  output logic                           shift_SPI,
  output logic                           image_ready,
  output logic                           overrun,
  output logic [$clog2(NUM_BYTES+1)-1:0] byte_count
);

  localparam int CW = $clog2(NUM_BYTES + 1);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(NUM_BYTES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, FULL} state_t;

  logic [1:0]            r_sclk_s;
  logic [1:0]            r_ss_s;
  logic [1:0]            r_mosi_s;
  logic                  r_sclk_q;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [BW-1:0]         r_bit_cnt;
  logic                  r_byte_done;
  logic [DATA_WIDTH-1:0] r_spi_in;
  logic                  r_write_en;
  logic                  r_image_ready;
  logic                  r_overrun;
  logic [CW-1:0]         r_byte_count;
  state_t                r_state;

  logic w_sclk_rise;
  logic w_ss_high;
  logic w_shift;

  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_q;
  assign w_ss_high   = r_ss_s[1];
  assign w_shift     = w_sclk_rise & ~w_ss_high;

  assign spi_in      = r_spi_in;
  assign write_en    = r_write_en;
  assign shift_SPI   = r_write_en;
  assign image_ready = r_image_ready;
  assign overrun     = r_overrun;
  assign byte_count  = r_byte_count;

  // Idle values of the synchronisers match a deselected, quiet bus.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sclk_s <= 2'b00;
      r_ss_s   <= 2'b11;
      r_mosi_s <= 2'b00;
      r_sclk_q <= 1'b0;
    end else begin
      r_sclk_s <= {r_sclk_s[0], sclk};
      r_ss_s   <= {r_ss_s[0], ss_n};
      r_mosi_s <= {r_mosi_s[0], mosi};
      r_sclk_q <= r_sclk_s[1];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_byte_done <= 1'b0;
    end else begin
      r_byte_done <= w_shift && (r_bit_cnt == LAST_BIT);
      if (w_ss_high) begin
        r_bit_cnt <= '0;
      end else if (w_sclk_rise) begin
        r_shreg   <= {r_shreg[DATA_WIDTH-2:0], r_mosi_s[1]};
        r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state       <= IDLE;
      r_spi_in      <= '0;
      r_write_en    <= 1'b0;
      r_image_ready <= 1'b0;
      r_overrun     <= 1'b0;
      r_byte_count  <= '0;
    end else begin
      r_write_en <= 1'b0;
      case (r_state)
        IDLE, RECV: begin
          if (r_byte_done) begin
            r_write_en   <= 1'b1;
            r_spi_in     <= r_shreg;
            r_byte_count <= r_byte_count + CNT_ONE;
            r_state      <= WRITE;
          end else begin
            r_state <= w_ss_high ? IDLE : RECV;
          end
        end
        WRITE: begin
          if (r_byte_count == FULL_CNT) begin
            r_image_ready <= 1'b1;
            r_state       <= FULL;
          end else begin
            r_state <= w_ss_high ? IDLE : RECV;
          end
        end
        FULL: begin
          // The ack rearms first, so a byte landing with it starts the next image.
          if (image_ack) begin
            r_image_ready <= 1'b0;
            r_overrun     <= 1'b0;
            if (r_byte_done) begin
              r_write_en   <= 1'b1;
              r_spi_in     <= r_shreg;
              r_byte_count <= CNT_ONE;
              r_state      <= WRITE;
            end else begin
              r_byte_count <= '0;
              r_state      <= w_ss_high ? IDLE : RECV;
            end
          end else if (r_byte_done) begin
            r_overrun <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_spi_loader.sv
// tb/tb_pixel_spi_loader.sv - scoreboard bench for pixel_spi_loader
module tb_pixel_spi_loader;
  localparam int NB = 72;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       sclk = 1'b0;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic       image_ack = 1'b0;
  logic [7:0] spi_in;
  logic       write_en;
  logic       shift_SPI;
  logic       image_ready;
  logic       overrun;
  logic [6:0] byte_count;

  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_cnt = 0;
  logic [14:0] sb[$];
  logic [7:0]  bufm[NB];

  pixel_spi_loader #(.NUM_BYTES(NB), .DATA_WIDTH(8)) dut (
    .clk(clk), .n_rst(n_rst), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .image_ack(image_ack), .spi_in(spi_in), .write_en(write_en),
    .shift_SPI(shift_SPI), .image_ready(image_ready), .overrun(overrun),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe cycle pops one expected {byte_count, spi_in} pair.
  always @(negedge clk) begin
    if (n_rst && (write_en || shift_SPI)) begin
      logic [14:0] e;
      n_cmp++;
      if (!(write_en && shift_SPI)) begin
        n_err++;
        $display("FAIL strobe_pair: got write_en=%0b shift_SPI=%0b expected both 1", write_en, shift_SPI);
      end else if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: got spi_in=%02h count=%0d expected no strobe", spi_in, byte_count);
      end else begin
        e = sb.pop_front();
        if ({byte_count, spi_in} !== e) begin
          n_err++;
          $display("FAIL strobe_data: got count=%0d byte=%02h expected count=%0d byte=%02h",
                   byte_count, spi_in, e[14:8], e[7:0]);
        end
      end
      for (int i = NB - 1; i > 0; i--) bufm[i] = bufm[i-1];
      bufm[0] = spi_in;
    end
  end

  task automatic spi_bit(input logic b);
    mosi = b;
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic strobe);
    if (strobe) begin
      exp_cnt++;
      sb.push_back({7'(exp_cnt), d});
    end
    for (int i = 7; i >= 0; i--) spi_bit(d[i]);
    repeat (2) @(negedge clk);
  endtask

  task automatic frame_begin();
    sclk = 1'b0;
    ss_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end();
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    ss_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    sclk = 1'b0;
    ss_n = 1'b1;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
  endtask

  task automatic pulse_ack();
    image_ack = 1'b1;
    @(negedge clk);
    image_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    while (!image_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(image_ready), 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_write_en"}, 32'(write_en), 0);
    chk({tag, "_shift_SPI"}, 32'(shift_SPI), 0);
    chk({tag, "_spi_in"}, 32'(spi_in), 0);
    chk({tag, "_image_ready"}, 32'(image_ready), 0);
    chk({tag, "_overrun"}, 32'(overrun), 0);
    chk({tag, "_byte_count"}, 32'(byte_count), 0);
  endtask

  initial begin
    logic [7:0] d;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    n_rst = 1'b1;
    @(negedge clk);

    // Single byte, then an ack outside FULL must be ignored.
    frame_begin();
    send_byte(8'hA5, 1'b1);
    frame_end();
    chk("t1_count", 32'(byte_count), 1);
    pulse_ack();
    chk("t1_ack_ignored_count", 32'(byte_count), 1);
    chk("t1_ack_ignored_ready", 32'(image_ready), 0);

    // Full image of 0x00..0x47.
    do_reset();
    frame_begin();
    for (int i = 0; i < NB; i++) send_byte(8'(i), 1'b1);
    wait_ready("t2_ready");
    chk("t2_count", 32'(byte_count), 72);
    chk("t2_buf_top", 32'(bufm[NB-1]), 8'h00);
    chk("t2_buf_next", 32'(bufm[NB-2]), 8'h01);
    chk("t2_overrun", 32'(overrun), 0);

    // Byte while full is dropped and flagged; ack rearms.
    send_byte(8'hFF, 1'b0);
    chk("t3_overrun", 32'(overrun), 1);
    chk("t3_count_held", 32'(byte_count), 72);
    chk("t3_ready_held", 32'(image_ready), 1);
    pulse_ack();
    exp_cnt = 0;
    chk("t3_ack_ready", 32'(image_ready), 0);
    chk("t3_ack_overrun", 32'(overrun), 0);
    chk("t3_ack_count", 32'(byte_count), 0);
    frame_end();

    // Partial byte discarded by ss_n rising.
    frame_begin();
    spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b0);
    frame_end();
    frame_begin();
    send_byte(8'h3C, 1'b1);
    frame_end();
    chk("t4_count", 32'(byte_count), 1);

    // Reset mid-image and mid-byte, then a fresh image.
    frame_begin();
    for (int i = 0; i < 40; i++) send_byte(8'(8'h80 + i), 1'b1);
    chk("t5_count_pre", 32'(byte_count), 41);
    spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b1);
    #2 n_rst = 1'b0;
    #1 chk_all_zero("t5_async");
    sclk = 1'b0;
    ss_n = 1'b1;
    mosi = 1'b0;
    chk("t5_no_pending", 32'(sb.size()), 0);
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk_all_zero("t5_held");
    n_rst = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
    frame_begin();
    for (int i = 0; i < NB; i++) send_byte(8'(3 * i + 1), 1'b1);
    wait_ready("t5_ready");
    chk("t5_count", 32'(byte_count), 72);

    // Last bit of a byte lands in the same cycle as image_ack.
    d = 8'h5A;
    exp_cnt = 1;
    sb.push_back({7'd1, d});
    for (int i = 7; i >= 1; i--) spi_bit(d[i]);
    mosi = d[0];
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (3) @(negedge clk);
    image_ack = 1'b1;
    @(negedge clk);
    image_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_ready", 32'(image_ready), 0);
    chk("t6_count", 32'(byte_count), 1);
    chk("t6_overrun", 32'(overrun), 0);
    frame_end();

    chk("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL timeout: got no completion expected finish within bound");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
